ham_link_scheduler: RTL and testbench

HAM_LINK_SCHEDULER -- requirements
Module: ham_link_scheduler

---
 rtl/ham_pkg.sv | 29 ++
 rtl/ham_link_scheduler_if.sv | 33 +++
 rtl/ham74_encoder.sv | 11 +
 rtl/ham_link_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_ham_link_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ham_pkg.sv
// Shared types, widths and the Hamming(7,4) encode function for the link scheduler.
package ham_pkg;

   localparam int DATA_W = 4;
   localparam int DEST_W = 4;
   localparam int CODE_W = 7;
   localparam int PKT_W  = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   // Data bits sit at positions 2,4,5,6; parity bits at 0,1,3.
   function automatic logic [CODE_W-1:0] ham74_encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] c;
      c    = '0;
      c[2] = d[0];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      c[0] = c[2] ^ c[4] ^ c[6];
      c[1] = c[2] ^ c[5] ^ c[6];
      c[3] = c[4] ^ c[5] ^ c[6];
      return c;
   endfunction

endpackage

// File: rtl/ham_link_scheduler_if.sv
// Requester, link and response signals of the scheduler; master = scheduler side.
interface ham_link_scheduler_if
   import ham_pkg::*;
#(
   parameter int NUM_REQ = 4
) ();

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0][DEST_W-1:0] req_dest;
   logic                           pkt_valid;
   logic                           pkt_ready;
   logic [PKT_W-1:0]               pkt_data;
   logic                           resp_valid;
   logic                           resp_ok;
   logic                           drop_valid;
   logic [ID_W-1:0]                drop_id;
   logic                           busy;

   modport master (
      input  req_valid, req_data, req_dest, pkt_ready, resp_valid, resp_ok,
      output req_ready, pkt_valid, pkt_data, drop_valid, drop_id, busy
   );

   modport slave (
      output req_valid, req_data, req_dest, pkt_ready, resp_valid, resp_ok,
      input  req_ready, pkt_valid, pkt_data, drop_valid, drop_id, busy
   );

endinterface

// File: rtl/ham74_encoder.sv
// Combinational Hamming(7,4) encoder.
module ham74_encoder
   import ham_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] code_o
);

   assign code_o = ham74_encode(data_i);

endmodule

// File: rtl/ham_link_scheduler.sv
// Round-robin requester arbiter that Hamming-encodes one nibble at a time onto a link,
// retrying on NACK/timeout and dropping the packet once the retry budget is spent.
module ham_link_scheduler
   import ham_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_RETRY    = 3,
   parameter int RESP_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   ham_link_scheduler_if.master  bus
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [ID_W-1:0]    cur_idx_q, cur_idx_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               pkt_valid_q, pkt_valid_d;
   logic [PKT_W-1:0]   pkt_data_q, pkt_data_d;
   logic               drop_valid_q, drop_valid_d;
   logic [ID_W-1:0]    drop_id_q, drop_id_d;
   logic               busy_q, busy_d;

   logic               pick_found_s;
   logic [ID_W-1:0]    pick_idx_s;
   logic [ID_W-1:0]    cand_s;
   logic               hit_s;
   logic               xfer_s;
   logic               ack_s;
   logic               fail_s;
   logic               drop_s;
   logic [CODE_W-1:0]  code_s;

   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
      int c;
      c = int'(base) + k;
      if (c >= NUM_REQ) begin
         c = c - NUM_REQ;
      end else begin
         c = c;
      end
      return ID_W'(c);
   endfunction

   ham74_encoder u_enc (
      .data_i (bus.req_data[cur_idx_q]),
      .code_o (code_s)
   );

   // Round-robin search starting just after the last served requester.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      cand_s       = '0;
      hit_s        = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s       = rr_idx(last_q, k);
         hit_s        = !pick_found_s && bus.req_valid[cand_s];
         pick_idx_s   = hit_s ? cand_s : pick_idx_s;
         pick_found_s = pick_found_s | hit_s;
      end
   end

   assign xfer_s = (state_q == ST_IDLE) && ((bus.req_valid & req_ready_q) != '0);
   assign ack_s  = (state_q == ST_WAIT) && bus.resp_valid && bus.resp_ok;
   assign fail_s = (state_q == ST_WAIT) &&
                   ((bus.resp_valid && !bus.resp_ok) || (!bus.resp_valid && (tmo_q == TMO_LAST)));
   assign drop_s = fail_s && (retry_q >= RTY_MAX);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_s) state_d = ST_SEND;
            else        state_d = ST_IDLE;
         end
         ST_SEND: begin
            if (bus.pkt_ready) state_d = ST_WAIT;
            else               state_d = ST_SEND;
         end
         ST_WAIT: begin
            if (ack_s || drop_s) state_d = ST_IDLE;
            else if (fail_s)     state_d = ST_SEND;
            else                 state_d = ST_WAIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and datapath next values; a grant is offered for one cycle, then re-arbitrated.
   always_comb begin
      req_ready_d  = '0;
      cur_idx_d    = cur_idx_q;
      last_d       = last_q;
      retry_d      = retry_q;
      tmo_d        = tmo_q;
      pkt_data_d   = pkt_data_q;
      drop_valid_d = 1'b0;
      drop_id_d    = drop_id_q;
      pkt_valid_d  = (state_d == ST_SEND);
      busy_d       = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (xfer_s) begin
               pkt_data_d = {bus.req_dest[cur_idx_q], code_s};
               retry_d    = '0;
            end else if ((req_ready_q == '0) && pick_found_s) begin
               req_ready_d = NUM_REQ'(1) << pick_idx_s;
               cur_idx_d   = pick_idx_s;
            end else begin
               req_ready_d = '0;
            end
         end
         ST_SEND: begin
            if (bus.pkt_ready) tmo_d = '0;
            else               tmo_d = tmo_q;
         end
         ST_WAIT: begin
            if (ack_s) begin
               last_d = cur_idx_q;
            end else if (drop_s) begin
               drop_valid_d = 1'b1;
               drop_id_d    = cur_idx_q;
               last_d       = cur_idx_q;
            end else if (fail_s) begin
               retry_d = retry_q + RTY_W'(1);
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            req_ready_d = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready_q  <= '0;
         cur_idx_q    <= '0;
         last_q       <= LAST_RST;
         retry_q      <= '0;
         tmo_q        <= '0;
         pkt_valid_q  <= 1'b0;
         pkt_data_q   <= '0;
         drop_valid_q <= 1'b0;
         drop_id_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         req_ready_q  <= req_ready_d;
         cur_idx_q    <= cur_idx_d;
         last_q       <= last_d;
         retry_q      <= retry_d;
         tmo_q        <= tmo_d;
         pkt_valid_q  <= pkt_valid_d;
         pkt_data_q   <= pkt_data_d;
         drop_valid_q <= drop_valid_d;
         drop_id_q    <= drop_id_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.pkt_valid  = pkt_valid_q;
   assign bus.pkt_data   = pkt_data_q;
   assign bus.drop_valid = drop_valid_q;
   assign bus.drop_id    = drop_id_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ham_link_scheduler.sv
// Directed bench for ham_link_scheduler: scoreboard of expected packets, immediate-assert checks.
module tb_ham_link_scheduler;
   import ham_pkg::*;

   localparam int NUM_REQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ham_link_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   ham_link_scheduler #(.NUM_REQ(NUM_REQ), .MAX_RETRY(3), .RESP_TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_pass  = 0;
   int          n_fail  = 0;
   int          n_total = 0;
   int          sends   = 0;
   logic [10:0] exp_q[$];

   function automatic logic [6:0] model_code(input logic [3:0] d);
      return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] d, input logic [3:0] dst);
      bus.req_valid[i] = v;
      bus.req_data[i]  = d;
      bus.req_dest[i]  = dst;
   endtask

   // Wait (bounded) for a grant, record the expected packet, then let the transfer edge pass.
   task automatic wait_grant(input string tag, output int idx, output int waited);
      idx    = -1;
      waited = 0;
      while (((bus.req_ready & bus.req_valid) == 4'b0000) && (waited < 30)) begin
         tick();
         waited++;
      end
      check({tag, "_onehot"}, 32'($countones(bus.req_ready)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_ready[i] && bus.req_valid[i]) idx = i;
      end
      if (idx >= 0) exp_q.push_back({bus.req_dest[idx], model_code(bus.req_data[idx])});
      tick();
      check({tag, "_pkt_valid_lat"}, 32'(bus.pkt_valid), 32'd1);
   endtask

   // Complete one link handshake after `stall` not-ready cycles, comparing against the scoreboard.
   task automatic send_pkt(input string tag, input int stall, input logic resp_in_send);
      logic [10:0] held;
      logic [31:0] exp_v;
      bus.pkt_ready  = 1'b0;
      bus.resp_valid = resp_in_send;
      bus.resp_ok    = 1'b1;
      held           = bus.pkt_data;
      for (int k = 0; k < stall; k++) begin
         tick();
         check({tag, "_stall_valid"}, 32'(bus.pkt_valid), 32'd1);
         check({tag, "_stall_data"}, 32'(bus.pkt_data), 32'(held));
      end
      bus.pkt_ready = 1'b1;
      if (exp_q.size() > 0) exp_v = 32'(exp_q.pop_front());
      else                  exp_v = 32'hDEAD_BEEF;
      check({tag, "_pkt_data"}, 32'(bus.pkt_data), exp_v);
      sends++;
      tick();
      bus.pkt_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      check({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_wait_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
   endtask

   task automatic respond(input logic ok);
      bus.resp_valid = 1'b1;
      bus.resp_ok    = ok;
      tick();
      bus.resp_valid = 1'b0;
      bus.resp_ok    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
      check({tag, "_pkt_data"}, 32'(bus.pkt_data), 32'd0);
      check({tag, "_drop_valid"}, 32'(bus.drop_valid), 32'd0);
      check({tag, "_drop_id"}, 32'(bus.drop_id), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int          idx;
      int          w;
      int          n;
      int          rr_order[5];
      logic [3:0]  seq_data[3];
      logic [6:0]  seq_code[3];
      logic [10:0] pkt_v;

      rr_order = '{0, 1, 2, 3, 0};
      seq_data = '{4'b0000, 4'b0101, 4'b1111};
      seq_code = '{7'b0000000, 7'b0101101, 7'b1111111};

      bus.req_valid  = 4'b0000;
      bus.req_data   = '0;
      bus.req_dest   = '0;
      bus.pkt_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_ok    = 1'b0;

      // Reset, with all requesters already valid so req_ready must still stay low.
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i * 3 + 1), 4'(i + 8));
      tick();
      tick();
      check_reset_outputs("reset");

      // All requesters valid continuously: round-robin 0,1,2,3,0, back-to-back grants.
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         wait_grant("rr", idx, w);
         check("rr_idx", 32'(idx), 32'(rr_order[g]));
         if (g > 0) check("rr_grant_lat", 32'(w), 32'd1);
         send_pkt("rr", 0, 1'b0);
         respond(1'b1);
         check("rr_idle", 32'(bus.busy), 32'd0);
      end
      bus.req_valid = 4'b0000;

      // Single req0, data 1001, dest 3.
      set_req(0, 1'b1, 4'b1001, 4'h3);
      sends = 0;
      wait_grant("single", idx, w);
      bus.req_valid[0] = 1'b0;
      check("single_idx", 32'(idx), 32'd0);
      check("single_code", 32'(bus.pkt_data), 32'({4'h3, 7'b1001100}));
      send_pkt("single", 0, 1'b0);
      respond(1'b1);
      check("single_idle", 32'(bus.busy), 32'd0);
      check("single_no_resend", 32'(bus.pkt_valid), 32'd0);
      check("single_sends", 32'(sends), 32'd1);

      // Sequential data patterns with known codes.
      for (int s = 0; s < 3; s++) begin
         set_req(0, 1'b1, seq_data[s], 4'h5);
         wait_grant("seq", idx, w);
         bus.req_valid[0] = 1'b0;
         check("seq_code", 32'(bus.pkt_data[6:0]), 32'(seq_code[s]));
         send_pkt("seq", 0, 1'b0);
         respond(1'b1);
      end

      // Req2 with pkt_ready low for 5 cycles; responses during SEND/handshake ignored.
      set_req(2, 1'b1, 4'b0110, 4'hC);
      wait_grant("stall", idx, w);
      bus.req_valid[2] = 1'b0;
      check("stall_idx", 32'(idx), 32'd2);
      send_pkt("stall", 5, 1'b1);
      respond(1'b1);
      check("stall_idle", 32'(bus.busy), 32'd0);

      // Four NACKs on req3: four sends, then a one-cycle drop pulse.
      set_req(3, 1'b1, 4'b1010, 4'hA);
      pkt_v = {4'hA, model_code(4'b1010)};
      sends = 0;
      wait_grant("drop", idx, w);
      bus.req_valid[3] = 1'b0;
      for (int r = 0; r < 4; r++) begin
         send_pkt("drop", 0, 1'b0);
         respond(1'b0);
         if (r < 3) begin
            check("drop_early", 32'(bus.drop_valid), 32'd0);
            check("drop_resend", 32'(bus.pkt_valid), 32'd1);
            exp_q.push_back(pkt_v);
         end else begin
            check("drop_valid", 32'(bus.drop_valid), 32'd1);
            check("drop_id", 32'(bus.drop_id), 32'd3);
            check("drop_idle", 32'(bus.busy), 32'd0);
         end
      end
      check("drop_sends", 32'(sends), 32'd4);
      tick();
      check("drop_pulse_end", 32'(bus.drop_valid), 32'd0);

      // Three NACKs then ok on req1: no drop.
      set_req(1, 1'b1, 4'b0011, 4'h7);
      pkt_v = {4'h7, model_code(4'b0011)};
      wait_grant("retry_ok", idx, w);
      bus.req_valid[1] = 1'b0;
      check("retry_ok_idx", 32'(idx), 32'd1);
      for (int r = 0; r < 3; r++) begin
         send_pkt("retry_ok", 0, 1'b0);
         respond(1'b0);
         check("retry_ok_nodrop", 32'(bus.drop_valid), 32'd0);
         exp_q.push_back(pkt_v);
      end
      send_pkt("retry_ok", 0, 1'b0);
      respond(1'b1);
      check("retry_ok_final_drop", 32'(bus.drop_valid), 32'd0);
      check("retry_ok_idle", 32'(bus.busy), 32'd0);

      // No response: resend after 15 WAIT cycles, then reset mid-WAIT.
      set_req(1, 1'b1, 4'b0110, 4'h2);
      pkt_v = {4'h2, model_code(4'b0110)};
      wait_grant("tmo", idx, w);
      bus.req_valid[1] = 1'b0;
      send_pkt("tmo", 0, 1'b0);
      n = 0;
      while (!bus.pkt_valid && (n < 40)) begin
         tick();
         n++;
      end
      check("tmo_cycles", 32'(n), 32'd15);
      exp_q.push_back(pkt_v);
      send_pkt("tmo_resend", 0, 1'b0);
      tick();
      tick();
      tick();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i + 4), 4'(i));
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      wait_grant("post_rst", idx, w);
      check("post_rst_idx", 32'(idx), 32'd0);
      check("post_rst_nodrop", 32'(bus.drop_valid), 32'd0);
      bus.req_valid = 4'b0000;
      send_pkt("post_rst", 0, 1'b0);
      respond(1'b1);
      check("post_rst_idle", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
